// File: rtl/systolic_job_scheduler_if.sv
// Handshake bundle between the job scheduler, its command source, the systolic array
// and the result consumer. The scheduler uses the slave modport, the host side the master.
interface systolic_job_scheduler_if #(
    parameter int TILE_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [TILE_W-1:0] cmd_num_tiles;
    logic              cmd_reload_w;
    logic              arr_load_weights;
    logic              arr_enable;
    logic              arr_done;
    logic [TILE_W-1:0] tile_idx;
    logic              res_valid;
    logic              res_ready;
    logic              busy;
    logic              job_done;
    logic              err_timeout;

    modport master (
        output cmd_valid, cmd_num_tiles, cmd_reload_w, arr_done, res_ready,
        input  cmd_ready, arr_load_weights, arr_enable, tile_idx, res_valid,
               busy, job_done, err_timeout
    );

    modport slave (
        input  cmd_valid, cmd_num_tiles, cmd_reload_w, arr_done, res_ready,
        output cmd_ready, arr_load_weights, arr_enable, tile_idx, res_valid,
               busy, job_done, err_timeout
    );
endinterface

// File: rtl/systolic_job_scheduler.sv
// Sequences a weight-stationary systolic array through a multi-tile job.
// Optional SCHED_PERF_CNT_EN adds saturating busy/stall performance counters.
module systolic_job_scheduler #(
    parameter int TILE_W         = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    systolic_job_scheduler_if.slave sif
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       perf_busy_cycles,
    output logic [CNT_W-1:0]       perf_stall_cycles
`endif
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        ARM    = 3'd2,
        RUN    = 3'd3,
        RESULT = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TILE_W-1:0] num_tiles;
    logic [TILE_W-1:0] tile_idx;
    logic              w_valid;
    logic              err_timeout;
    logic [TO_W-1:0]   to_cnt;
    logic              last_tile;
    logic              timed_out;

    logic cmd_ready;
    logic arr_enable;
    logic arr_load_weights;
    logic res_valid;
    logic busy;
    logic job_done;

    assign last_tile = (tile_idx == (num_tiles - TILE_W'(1)));
    assign timed_out = (to_cnt == TO_LAST) && !sif.arr_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ARM and RESULT both drive enable low so the array always sees a fresh rising edge.
    always_comb begin
        state_next       = state;
        cmd_ready        = 1'b0;
        arr_enable       = 1'b0;
        arr_load_weights = 1'b0;
        res_valid        = 1'b0;
        busy             = 1'b1;
        job_done         = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (sif.cmd_valid) begin
                    if (sif.cmd_num_tiles == '0) begin
                        state_next = FINISH;
                    end else if (sif.cmd_reload_w || !w_valid) begin
                        state_next = LOAD_W;
                    end else begin
                        state_next = ARM;
                    end
                end
            end
            LOAD_W: begin
                arr_enable       = 1'b1;
                arr_load_weights = 1'b1;
                state_next       = ARM;
            end
            ARM: begin
                state_next = RUN;
            end
            RUN: begin
                arr_enable = 1'b1;
                if (sif.arr_done) begin
                    state_next = RESULT;
                end else if (timed_out) begin
                    state_next = FINISH;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (sif.res_ready) begin
                    state_next = last_tile ? FINISH : RUN;
                end
            end
            FINISH: begin
                job_done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The timeout counter restarts whenever RUN is (re)entered, since every other state clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_tiles   <= '0;
            tile_idx    <= '0;
            w_valid     <= 1'b0;
            err_timeout <= 1'b0;
            to_cnt      <= '0;
        end else begin
            to_cnt <= (state == RUN) ? to_cnt + TO_W'(1) : '0;
            case (state)
                IDLE: begin
                    if (sif.cmd_valid) begin
                        num_tiles   <= sif.cmd_num_tiles;
                        tile_idx    <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                LOAD_W: begin
                    w_valid <= 1'b1;
                end
                RUN: begin
                    if (timed_out) begin
                        err_timeout <= 1'b1;
                        w_valid     <= 1'b0;
                    end
                end
                RESULT: begin
                    if (sif.res_ready && !last_tile) begin
                        tile_idx <= tile_idx + TILE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    // Counters saturate and are never cleared by a new job, only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && (perf_busy_cycles != '1)) begin
                perf_busy_cycles <= perf_busy_cycles + CNT_W'(1);
            end
            if ((state == RESULT) && !sif.res_ready && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
            end
        end
    end
`endif

    assign sif.cmd_ready        = cmd_ready;
    assign sif.arr_enable       = arr_enable;
    assign sif.arr_load_weights = arr_load_weights;
    assign sif.res_valid        = res_valid;
    assign sif.busy             = busy;
    assign sif.job_done         = job_done;
    assign sif.tile_idx         = tile_idx;
    assign sif.err_timeout      = err_timeout;
endmodule

// File: tb/tb_systolic_job_scheduler.sv
// Scoreboard bench for systolic_job_scheduler: directed jobs drive a small array model,
// expected tile handshakes and job completions are queued and checked by a monitor.
module tb_systolic_job_scheduler;
    logic clk;
    logic reset;

    systolic_job_scheduler_if #(.TILE_W(8)) sif ();

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_stall_cycles;
`endif

    systolic_job_scheduler #(
        .TILE_W(8),
        .TIMEOUT_CYCLES(64),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sif(sif)
`ifdef SCHED_PERF_CNT_EN
        ,
        .perf_busy_cycles(perf_busy_cycles),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       is_done;
        logic [7:0] tile;
        bit       err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pushResult(input logic [7:0] tile);
        exp_t e;
        e.is_done = 1'b0;
        e.tile    = tile;
        e.err     = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic pushDone(input bit err);
        exp_t e;
        e.is_done = 1'b1;
        e.tile    = 8'd0;
        e.err     = err;
        exp_q.push_back(e);
    endtask

    // Array model: done rises 8 cycles after a compute enable edge, clears when enable drops.
    logic       done_en;
    logic       en_q;
    logic       active;
    logic [3:0] acnt;
    logic       arr_done_r;
    assign sif.arr_done = arr_done_r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q       <= 1'b0;
            active     <= 1'b0;
            acnt       <= 4'd0;
            arr_done_r <= 1'b0;
        end else begin
            en_q <= sif.arr_enable;
            if (!sif.arr_enable) begin
                arr_done_r <= 1'b0;
                active     <= 1'b0;
            end else if (!en_q && !sif.arr_load_weights) begin
                active <= 1'b1;
                acnt   <= 4'd0;
            end else if (active) begin
                if (acnt == 4'd7) begin
                    arr_done_r <= done_en;
                    active     <= 1'b0;
                end else begin
                    acnt <= acnt + 4'd1;
                end
            end
        end
    end

    // Monitor: every handshake and every job_done pulse must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (sif.res_valid && sif.res_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result: got tile %0d expected none", sif.tile_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("sb_kind_result", 32'(e.is_done), 32'd0);
                    checkOutput("sb_tile_idx", 32'(sif.tile_idx), 32'(e.tile));
                end
            end
            if (sif.job_done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_job_done: got pulse expected none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("sb_kind_done", 32'(e.is_done), 32'd1);
                    checkOutput("sb_err_timeout", 32'(sif.err_timeout), 32'(e.err));
                end
            end
        end
    end

    int          cnt_load;
    int          cnt_en;
    int          cnt_res;
    int          cnt_en_low_busy;
    int          done_idx;
    int          last_res_idx;
    int          first_res_idx;
    int          first_arr_done_idx;
    logic        err_at1;
    logic [15:0] load_hist;
    logic [15:0] en_hist;

    task automatic applyStimulus(input logic [7:0] num, input logic reload);
        sif.cmd_valid     = 1'b1;
        sif.cmd_num_tiles = num;
        sif.cmd_reload_w  = reload;
        @(negedge clk);
        checkOutput("cmd_ready_idle", 32'(sif.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        sif.cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int idx;
        idx                = 0;
        cnt_load           = 0;
        cnt_en             = 0;
        cnt_res            = 0;
        cnt_en_low_busy    = 0;
        done_idx           = -1;
        last_res_idx       = -1;
        first_res_idx      = -1;
        first_arr_done_idx = -1;
        err_at1            = 1'b0;
        load_hist          = '0;
        en_hist            = '0;
        while (done_idx < 0 && idx < budget) begin
            @(negedge clk);
            idx++;
            if (idx == 1) err_at1 = sif.err_timeout;
            if (sif.arr_load_weights) begin
                cnt_load++;
                if (idx < 16) load_hist[idx] = 1'b1;
            end
            if (sif.arr_enable) begin
                cnt_en++;
                if (idx < 16) en_hist[idx] = 1'b1;
            end else if (sif.busy && !sif.job_done) begin
                cnt_en_low_busy++;
            end
            if (sif.res_valid) begin
                cnt_res++;
                last_res_idx = idx;
                if (first_res_idx < 0) first_res_idx = idx;
            end
            if (sif.arr_done && first_arr_done_idx < 0) first_arr_done_idx = idx;
            if (sif.job_done) done_idx = idx;
        end
        if (done_idx < 0) checkOutput("job_done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] perf_before;
    int          found;

    initial begin
        reset             = 1'b1;
        sif.cmd_valid     = 1'b0;
        sif.cmd_num_tiles = 8'd0;
        sif.cmd_reload_w  = 1'b0;
        sif.res_ready     = 1'b1;
        done_en           = 1'b1;
        perf_before       = '0;
        found             = 0;
        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(sif.cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(sif.busy), 32'd0);
        checkOutput("rst_enable", 32'(sif.arr_enable), 32'd0);
        checkOutput("rst_tile_idx", 32'(sif.tile_idx), 32'd0);
        checkOutput("rst_err", 32'(sif.err_timeout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] job 1: one tile with weight reload");
        pushResult(8'd0);
        pushDone(1'b0);
        applyStimulus(8'd1, 1'b1);
        waitDone(2000);
        checkOutput("j1_load_cycles", 32'(cnt_load), 32'd1);
        checkOutput("j1_load_at_t1", 32'(load_hist[1]), 32'd1);
        checkOutput("j1_en_at_t1", 32'(en_hist[1]), 32'd1);
        checkOutput("j1_arm_low_t2", 32'(en_hist[2]), 32'd0);
        checkOutput("j1_run_at_t3", 32'(en_hist[3]), 32'd1);
        checkOutput("j1_res_cycles", 32'(cnt_res), 32'd1);
        checkOutput("j1_res_after_done", 32'(first_res_idx), 32'(first_arr_done_idx + 1));
        checkOutput("j1_done_after_hs", 32'(done_idx), 32'(last_res_idx + 1));
        @(negedge clk);
        checkOutput("j1_cmd_ready_after", 32'(sif.cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] job 2: three tiles, weights kept");
        pushResult(8'd0);
        pushResult(8'd1);
        pushResult(8'd2);
        pushDone(1'b0);
        applyStimulus(8'd3, 1'b0);
        waitDone(2000);
        checkOutput("j2_no_load", 32'(cnt_load), 32'd0);
        checkOutput("j2_arm_at_t1", 32'(en_hist[1]), 32'd0);
        checkOutput("j2_res_cycles", 32'(cnt_res), 32'd3);
        checkOutput("j2_enable_low_cycles", 32'(cnt_en_low_busy), 32'd4);
        checkOutput("j2_done_after_hs", 32'(done_idx), 32'(last_res_idx + 1));

        $display("[TB] job 3: consumer stalls tile 0");
        pushResult(8'd0);
        pushResult(8'd1);
        pushDone(1'b0);
        sif.res_ready = 1'b0;
        applyStimulus(8'd2, 1'b0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sif.res_valid) begin
                found = 1;
                break;
            end
        end
        checkOutput("j3_res_seen", 32'(found), 32'd1);
`ifdef SCHED_PERF_CNT_EN
        perf_before = perf_stall_cycles;
`endif
        for (int i = 0; i < 6; i++) begin
            checkOutput("j3_res_valid_held", 32'(sif.res_valid), 32'd1);
            checkOutput("j3_tile_held", 32'(sif.tile_idx), 32'd0);
            checkOutput("j3_enable_low", 32'(sif.arr_enable), 32'd0);
            if (i < 5) begin
                @(posedge clk);
                #1;
                if (i == 4) sif.res_ready = 1'b1;
                @(negedge clk);
            end
        end
        waitDone(2000);
`ifdef SCHED_PERF_CNT_EN
        checkOutput("j3_perf_stall", perf_stall_cycles - perf_before, 32'd5);
`endif

        $display("[TB] job 4: array never finishes");
        done_en = 1'b0;
        pushDone(1'b1);
        applyStimulus(8'd2, 1'b0);
        waitDone(2000);
        checkOutput("j4_run_cycles", 32'(cnt_en), 32'd64);
        checkOutput("j4_no_result", 32'(cnt_res), 32'd0);
        @(negedge clk);
        checkOutput("j4_err_sticky", 32'(sif.err_timeout), 32'd1);
        @(posedge clk);
        #1;
        done_en = 1'b1;
        pushResult(8'd0);
        pushDone(1'b0);
        applyStimulus(8'd1, 1'b0);
        waitDone(2000);
        checkOutput("j5_reload_after_to", 32'(cnt_load), 32'd1);
        checkOutput("j5_err_cleared", 32'(err_at1), 32'd0);

        $display("[TB] job 6: zero tiles");
`ifdef SCHED_PERF_CNT_EN
        perf_before = perf_busy_cycles;
`endif
        pushDone(1'b0);
        applyStimulus(8'd0, 1'b1);
        waitDone(2000);
        checkOutput("j6_done_idx", 32'(done_idx), 32'd1);
        checkOutput("j6_no_enable", 32'(cnt_en), 32'd0);
        checkOutput("j6_no_load", 32'(cnt_load), 32'd0);
`ifdef SCHED_PERF_CNT_EN
        checkOutput("j6_perf_busy", perf_busy_cycles - perf_before, 32'd1);
`endif

        $display("[TB] job 7: reset during tile 1 of 4");
        pushResult(8'd0);
        applyStimulus(8'd4, 1'b0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (sif.tile_idx == 8'd1 && sif.arr_enable) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("j7_run_tile1", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("j7_rst_cmd_ready", 32'(sif.cmd_ready), 32'd1);
        checkOutput("j7_rst_busy", 32'(sif.busy), 32'd0);
        checkOutput("j7_rst_enable", 32'(sif.arr_enable), 32'd0);
        checkOutput("j7_rst_res_valid", 32'(sif.res_valid), 32'd0);
        checkOutput("j7_rst_tile_idx", 32'(sif.tile_idx), 32'd0);
`ifdef SCHED_PERF_CNT_EN
        checkOutput("j7_rst_perf_busy", perf_busy_cycles, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        pushResult(8'd0);
        pushDone(1'b0);
        applyStimulus(8'd1, 1'b0);
        waitDone(2000);
        checkOutput("j8_reload_after_rst", 32'(cnt_load), 32'd1);

        repeat (3) @(negedge clk);
        checkOutput("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
